stall_ctrl: RTL

//  Generates stall/flush controls for the pipelined CPU's flopenr/floprc

---
 rtl/stall_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/stall_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes and multi-cycle
// execute holds, plus a saturating count of fetch-stall cycles.
module stall_ctrl #(
    parameter int MC_LATENCY = 4,
    parameter int REGW       = 5,
    parameter int CNTW       = 16
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic [REGW-1:0] Rs1D,
    input  logic [REGW-1:0] Rs2D,
    input  logic [REGW-1:0] RdE,
    input  logic            LoadE,
    input  logic            MultiStartE,
    input  logic            PCSrcE,
    output logic            StallF,
    output logic            StallD,
    output logic            StallE,
    output logic            FlushD,
    output logic            FlushE,
    output logic            MultiDoneE,
    output logic [CNTW-1:0] StallCnt
);

    localparam int CW = 5;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MC_LATENCY - 2);
    localparam bit SHORT_OP = (MC_LATENCY == 2);

    typedef enum logic {
        IDLE,
        MC
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          done_nxt;
    logic          lu;

    assign lu = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            cnt        <= '0;
            MultiDoneE <= 1'b0;
            StallCnt   <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            MultiDoneE <= done_nxt;
            if (StallF && (StallCnt != '1))
                StallCnt <= StallCnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        case (state)
            IDLE: begin
                if (PCSrcE) begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                end else if (MultiStartE) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    StallE = 1'b1;
                    // A two-cycle op has only its start cycle stalled, so it finishes here.
                    if (SHORT_OP) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = MC;
                        cnt_nxt   = CNT_LOAD;
                    end
                end else if (lu) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end
            end
            MC: begin
                StallF  = 1'b1;
                StallD  = 1'b1;
                StallE  = 1'b1;
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
